// File: rtl/uart_pkg.sv
// Shared types and encodings for the parameterised UART receiver.
// Consumers: uart_rx_param, uart_rx_tick_gen and their testbench.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_IDLE     = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_PARITY   = 3'd4,
        ST_STOP     = 3'd5
    } rx_state_t;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam int OVS_8  = 8;
    localparam int OVS_16 = 16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle: word, status flags and valid/ready.
// rx_break exists only when UART_RX_BREAK_DETECT_EN is defined.
interface uart_rx_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_ferror;
    logic              rx_perror;
    logic              rx_overrun;
`ifdef UART_RX_BREAK_DETECT_EN
    logic              rx_break;

    modport master (output rx_data, rx_valid, rx_ferror, rx_perror, rx_overrun, rx_break,
                    input  rx_ready);
    modport slave  (input  rx_data, rx_valid, rx_ferror, rx_perror, rx_overrun, rx_break,
                    output rx_ready);
`else
    modport master (output rx_data, rx_valid, rx_ferror, rx_perror, rx_overrun,
                    input  rx_ready);
    modport slave  (input  rx_data, rx_valid, rx_ferror, rx_perror, rx_overrun,
                    output rx_ready);
`endif
endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: counts 0..div and pulses tick on the wrap cycle.
// clear restarts the count at 0 so bit timing aligns to the start edge.
module uart_rx_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear || (cnt_reg == div)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = !clear && (cnt_reg == div);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised oversampling UART receiver with valid/ready output holding.
// Optional UART_RX_BREAK_DETECT_EN turns all-zero frames into an rx_break pulse.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
    input  logic             rxd,
    uart_rx_param_if.master  rx_if
);
    localparam int SYNC_STAGES = 2;
    localparam int TC_W = $clog2(OVS);
    localparam int BC_W = $clog2(DATA_W);
    localparam logic [TC_W-1:0] TICK_MID_LO = TC_W'(OVS/2 - 1);
    localparam logic [TC_W-1:0] TICK_MID    = TC_W'(OVS/2);
    localparam logic [TC_W-1:0] TICK_MID_HI = TC_W'(OVS/2 + 1);
    localparam logic [TC_W-1:0] TICK_LAST   = TC_W'(OVS - 1);
    localparam logic [BC_W-1:0] BIT_LAST    = BC_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxd_prev_reg;
    rx_state_t              state_reg;
    logic [TC_W-1:0]        tick_cnt_reg;
    logic [BC_W-1:0]        bit_cnt_reg;
    logic                   stop_cnt_reg;
    logic [1:0]             vote_reg;
    logic                   bit_reg;
    logic [DATA_W-1:0]      shift_reg;
    logic                   par_acc_reg;
    logic                   perr_acc_reg;
    logic                   ferr_acc_reg;
    logic [DIV_W-1:0]       div_reg;
    logic [1:0]             pmode_reg;
    logic                   stop2_reg;
    logic [DATA_W-1:0]      data_reg;
    logic                   valid_reg;
    logic                   ferror_reg;
    logic                   perror_reg;
    logic                   overrun_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_reg[gi] <= 1'b1;
                end else begin
                    sync_reg[gi] <= (gi == 0) ? rxd : sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    logic rxd_sync, start_edge, tick, tick_clear, parity_en, bit_now, last_stop, frame_ferr;

    assign rxd_sync   = sync_reg[SYNC_STAGES-1];
    assign start_edge = (state_reg == ST_IDLE) && rxd_prev_reg && !rxd_sync;
    assign tick_clear = (state_reg == ST_DISABLED) || start_edge;
    assign parity_en  = (pmode_reg == PAR_EVEN) || (pmode_reg == PAR_ODD);
    // Third vote sample is the live synchronised line on the MID_HI tick.
    assign bit_now    = maj3(vote_reg[1], vote_reg[0], rxd_sync);
    assign last_stop  = !stop2_reg || stop_cnt_reg;
    assign frame_ferr = ferr_acc_reg | ~bit_now;

    uart_rx_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .div   (div_reg),
        .tick  (tick)
    );

`ifdef UART_RX_BREAK_DETECT_EN
    logic zero_acc_reg, break_reg, frame_zero;
    assign frame_zero = zero_acc_reg & ~bit_now;
    assign rx_if.rx_break = break_reg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_prev_reg <= 1'b1;
            state_reg    <= ST_DISABLED;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            vote_reg     <= '0;
            bit_reg      <= 1'b0;
            shift_reg    <= '0;
            par_acc_reg  <= 1'b0;
            perr_acc_reg <= 1'b0;
            ferr_acc_reg <= 1'b0;
            div_reg      <= '0;
            pmode_reg    <= PAR_NONE;
            stop2_reg    <= 1'b0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            ferror_reg   <= 1'b0;
            perror_reg   <= 1'b0;
            overrun_reg  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_acc_reg <= 1'b0;
            break_reg    <= 1'b0;
`endif
        end else begin
            rxd_prev_reg <= rxd_sync;
`ifdef UART_RX_BREAK_DETECT_EN
            break_reg <= 1'b0;
`endif
            if (valid_reg && rx_if.rx_ready) begin
                valid_reg   <= 1'b0;
                ferror_reg  <= 1'b0;
                perror_reg  <= 1'b0;
                overrun_reg <= 1'b0;
            end

            if (!rx_en) begin
                state_reg    <= ST_DISABLED;
                tick_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
                stop_cnt_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_DISABLED: state_reg <= ST_IDLE;
                    ST_IDLE: begin
                        if (start_edge) begin
                            state_reg    <= ST_START;
                            tick_cnt_reg <= '0;
                            stop_cnt_reg <= 1'b0;
                            div_reg      <= baud_div;
                            pmode_reg    <= parity_mode;
                            stop2_reg    <= stop2;
                            par_acc_reg  <= 1'b0;
                            perr_acc_reg <= 1'b0;
                            ferr_acc_reg <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                            zero_acc_reg <= 1'b1;
`endif
                        end
                    end
                    default: begin
                        if (tick) begin
                            tick_cnt_reg <= (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + 1'b1;
                            if (tick_cnt_reg == TICK_MID_LO || tick_cnt_reg == TICK_MID)
                                vote_reg <= {vote_reg[0], rxd_sync};
                            if (tick_cnt_reg == TICK_MID_HI)
                                bit_reg <= bit_now;

                            if (state_reg == ST_STOP && last_stop && tick_cnt_reg == TICK_MID_HI) begin
                                // Deliver at mid final stop so the next start edge is never missed.
                                state_reg    <= ST_IDLE;
                                tick_cnt_reg <= '0;
                                stop_cnt_reg <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                                if (frame_zero) break_reg <= 1'b1; else
`endif
                                if (valid_reg && !rx_if.rx_ready) begin
                                    overrun_reg <= 1'b1;
                                end else begin
                                    data_reg   <= shift_reg;
                                    ferror_reg <= frame_ferr;
                                    perror_reg <= perr_acc_reg;
                                    valid_reg  <= 1'b1;
                                end
                            end else if (tick_cnt_reg == TICK_LAST) begin
                                case (state_reg)
                                    ST_START: state_reg <= bit_reg ? ST_IDLE : ST_DATA;
                                    ST_DATA: begin
                                        shift_reg   <= {bit_reg, shift_reg[DATA_W-1:1]};
                                        par_acc_reg <= par_acc_reg ^ bit_reg;
                                        if (bit_cnt_reg == BIT_LAST) begin
                                            bit_cnt_reg <= '0;
                                            state_reg   <= parity_en ? ST_PARITY : ST_STOP;
                                        end else begin
                                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                                        end
                                    end
                                    ST_PARITY: begin
                                        perr_acc_reg <= (par_acc_reg ^ bit_reg) != (pmode_reg == PAR_ODD);
                                        state_reg    <= ST_STOP;
                                    end
                                    default: begin
                                        ferr_acc_reg <= ferr_acc_reg | ~bit_reg;
                                        stop_cnt_reg <= 1'b1;
                                    end
                                endcase
`ifdef UART_RX_BREAK_DETECT_EN
                                if (state_reg != ST_START)
                                    zero_acc_reg <= zero_acc_reg & ~bit_reg;
`endif
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign rx_if.rx_data    = data_reg;
    assign rx_if.rx_valid   = valid_reg;
    assign rx_if.rx_ferror  = ferror_reg;
    assign rx_if.rx_perror  = perror_reg;
    assign rx_if.rx_overrun = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: table of frames plus corner sequences.
// Build with UART_RX_BREAK_DETECT_EN to exercise the break pulse instead of ferror delivery.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int DW       = 8;
    localparam int OVS      = 16;
    localparam int DIVW     = 16;
    localparam int BAUD_DIV = 3;
    localparam int BIT_CYC  = OVS * (BAUD_DIV + 1);
    localparam int NV       = 9;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            rx_en = 1'b0;
    logic [DIVW-1:0] baud_div = DIVW'(BAUD_DIV);
    logic [1:0]      parity_mode = PAR_NONE;
    logic            stop2 = 1'b0;
    logic            rxd = 1'b1;

    uart_rx_param_if #(.DATA_W(DW)) rx_if ();

    uart_rx_param #(.DATA_W(DW), .OVS(OVS), .DIV_W(DIVW)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_en       (rx_en),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rxd         (rxd),
        .rx_if       (rx_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        logic       ovr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pmode;
        logic       st2;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic       e_perr;
        logic       e_ferr;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[NV];
    int   total = 0;
    int   bad = 0;
    int   valid_events = 0;
    int   break_events = 0;
    int   snap;
    logic [15:0] fbits;
    int   fn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void build(input vec_t v, output logic [15:0] b, output int n);
        int idx;
        b = 16'hFFFF;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = v.data[i];
        idx = 9;
        if (v.pmode == PAR_EVEN || v.pmode == PAR_ODD) begin
            b[idx] = v.pbit;
            idx++;
        end
        b[idx] = v.s1;
        idx++;
        if (v.st2) begin
            b[idx] = v.s2;
            idx++;
        end
        n = idx;
    endfunction

    task automatic drive_bits(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            rxd = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * BIT_CYC && sb_q.size() != 0; i++) @(negedge clk);
        chk(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic send_vec(input vec_t v, input logic ovr);
        build(v, fbits, fn);
        parity_mode = v.pmode;
        stop2       = v.st2;
        sb_q.push_back('{data: v.data, ferr: v.e_ferr, perr: v.e_perr, ovr: ovr});
        drive_bits(fbits, fn);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        //            data   pmode     st2   pbit  s1    s2    perr  ferr
        vecs[0] = '{8'hA5, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, PAR_ODD,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h01, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h5A, PAR_NONE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, PAR_ODD,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hC3, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'h81, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{8'h96, PAR_NONE_ALT, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        fork
            forever begin
                @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
                if (rx_if.rx_break) begin
                    break_events++;
                    $display("rx break pulse at %0t", $time);
                end
`endif
                if (rx_if.rx_valid && rx_if.rx_ready) begin
                    valid_events++;
                    $display("rx word data=%02h ferr=%0b perr=%0b ovr=%0b", rx_if.rx_data,
                             rx_if.rx_ferror, rx_if.rx_perror, rx_if.rx_overrun);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("rx_data",    rx_if.rx_data,    mon_e.data);
                        chk("rx_ferror",  rx_if.rx_ferror,  mon_e.ferr);
                        chk("rx_perror",  rx_if.rx_perror,  mon_e.perr);
                        chk("rx_overrun", rx_if.rx_overrun, mon_e.ovr);
                    end
                end
            end
        join_none

        rx_if.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data",   rx_if.rx_data, 0);
        chk("reset_valid",  rx_if.rx_valid, 0);
        chk("reset_flags",  {rx_if.rx_ferror, rx_if.rx_perror, rx_if.rx_overrun}, 0);
        chk("reset_state",  32'(dut.state_reg), 32'(ST_DISABLED));
        chk("reset_sync",   dut.sync_reg, 2'b11);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("reset_break",  rx_if.rx_break, 0);
`endif
        reset = 1'b1;
        rx_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("enable_idle", 32'(dut.state_reg), 32'(ST_IDLE));

        for (int i = 0; i < NV; i++) begin
            send_vec(vecs[i], 1'b0);
            wait_drain($sformatf("vec%0d_drain", i));
        end

        // False start: line low for 3 ticks only.
        snap = valid_events;
        rxd = 1'b0;
        repeat (3 * (BAUD_DIV + 1)) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        chk("false_start_novalid", valid_events, snap);
        chk("false_start_idle", 32'(dut.state_reg), 32'(ST_IDLE));
        chk("false_start_flags", {rx_if.rx_valid, rx_if.rx_ferror, rx_if.rx_perror, rx_if.rx_overrun}, 0);

        // Overrun: second frame arrives while the first is still held.
        @(posedge clk); #1 rx_if.rx_ready = 1'b0;
        sb_q.push_back('{data: 8'h11, ferr: 1'b0, perr: 1'b0, ovr: 1'b1});
        parity_mode = PAR_NONE;
        stop2 = 1'b0;
        build('{8'h11, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}, fbits, fn);
        drive_bits(fbits, fn);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        build('{8'h22, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}, fbits, fn);
        drive_bits(fbits, fn);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk("ovr_held_valid", rx_if.rx_valid, 1);
        chk("ovr_held_data",  rx_if.rx_data, 8'h11);
        chk("ovr_flag",       rx_if.rx_overrun, 1);
        @(posedge clk); #1 rx_if.rx_ready = 1'b1;
        wait_drain("ovr_drain");
        @(negedge clk);
        chk("ovr_cleared", {rx_if.rx_valid, rx_if.rx_ferror, rx_if.rx_perror, rx_if.rx_overrun}, 0);

        // Reset asserted in the middle of a frame.
        snap = valid_events;
        build('{8'h77, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}, fbits, fn);
        drive_bits(fbits, 5);
        rxd = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_state", 32'(dut.state_reg), 32'(ST_DISABLED));
        chk("midreset_outputs", {rx_if.rx_data, rx_if.rx_valid, rx_if.rx_ferror,
                                 rx_if.rx_perror, rx_if.rx_overrun}, 0);
        reset = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clk);
        chk("midreset_nopulse", valid_events, snap);
        send_vec('{8'h42, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b0);
        wait_drain("post_reset_drain");

        // Line held low for 12 bit times.
        snap = valid_events;
        parity_mode = PAR_NONE;
        stop2 = 1'b0;
`ifndef UART_RX_BREAK_DETECT_EN
        sb_q.push_back('{data: 8'h00, ferr: 1'b1, perr: 1'b0, ovr: 1'b0});
`endif
        rxd = 1'b0;
        repeat (12 * BIT_CYC) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("break_pulses", break_events, 1);
        chk("break_novalid", valid_events, snap);
`else
        wait_drain("zero_frame_drain");
        chk("zero_frame_count", valid_events, snap + 1);
`endif
        chk("final_idle", 32'(dut.state_reg), 32'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter OVS, default 16, oversampling ticks per bit, legal values 8 or 16.
REQ-003 Parameter DIV_W, default 16, width of the baud divisor input.
REQ-004 Port clk, input, 1, single clock for all logic.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port rx_en, input, 1, receiver enable; 0 forces DISABLED.
REQ-007 Port baud_div, input, DIV_W, oversample tick every baud_div+1 clk cycles.
REQ-008 Port parity_mode, input, 2: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 Port stop2, input, 1, 1 = two stop bits expected.
REQ-010 Port rxd, input, 1, asynchronous serial line, idle high.
REQ-011 Port rx_data, output, DATA_W, received word, LSB first on the line.
REQ-012 Port rx_valid / rx_ready, output / input, 1 each, hold-until-accepted handshake.
REQ-013 Port rx_ferror, rx_perror, rx_overrun, output, 1 each, status qualified by rx_valid.
REQ-014 Port rx_break, output, 1, one-cycle pulse (present only with UART_RX_BREAK_DETECT_EN).

Function
REQ-015 rxd SHALL pass through a 2-flop synchroniser that resets to 1 before any use.
REQ-016 Tick generator SHALL count 0..baud_div and emit a one-cycle tick on wrap; it SHALL restart at 0 on leaving DISABLED and on every start-bit detection.
REQ-017 FSM states: DISABLED, IDLE, START, DATA, PARITY, STOP; rx_en=0 forces DISABLED from any state within one cycle; rx_en=1 in DISABLED moves to IDLE.
REQ-018 IDLE->START on the synchronised falling edge of rxd.
REQ-019 Each bit SHALL be decided by majority vote of ticks OVS/2-1, OVS/2, OVS/2+1 within the bit; the state advances on tick OVS-1.
REQ-020 START: majority high SHALL return to IDLE silently (false start), with no flags and no rx_valid.
REQ-021 DATA: DATA_W bits are shifted in LSB first; the bit counter wraps to 0 on exit.
REQ-022 PARITY is visited only when parity_mode is 01 or 10; perror = (XOR of data bits XOR parity bit) != (mode==odd).
REQ-023 STOP: one stop bit, or two when stop2=1; any stop bit voted low SHALL set ferror for the frame.
REQ-024 The frame SHALL be delivered at the mid-point of the final stop bit with rx_data, rx_ferror and rx_perror updated and rx_valid=1; errored frames are still delivered and the FSM returns to IDLE (no lock state).
REQ-025 rx_valid, rx_data and the flags SHALL hold until the cycle rx_valid&rx_ready; that cycle clears rx_valid, rx_ferror, rx_perror and rx_overrun.
REQ-026 A frame completing while rx_valid=1 and rx_ready=0 SHALL be discarded, the held word kept, and rx_overrun set.
REQ-027 A frame completing in the same cycle as a handshake SHALL load the new word with rx_valid staying 1.
REQ-028 baud_div, parity_mode and stop2 SHALL be sampled at start-bit detection and held for the frame.

Reset
REQ-029 While reset=0: state DISABLED, counters 0, rx_data 0, all flags and rx_valid 0, synchroniser 1.
REQ-030 Reset assertion mid-frame SHALL discard the partial frame; no output pulse on deassertion.

Configuration
REQ-031 With UART_RX_BREAK_DETECT_EN defined: a frame whose data, parity and stop bits are all 0 SHALL pulse rx_break for one cycle instead of asserting rx_valid; the FSM then waits in IDLE until rxd is high before re-arming.
REQ-032 Without the macro, rx_break SHALL be absent and such a frame SHALL be delivered as 0 with rx_ferror=1.

Structure
REQ-033 Package uart_pkg SHALL hold the state enumeration, the parity_mode encodings and the OVS legal values.
REQ-034 Sub-module uart_rx_tick_gen SHALL implement the baud divider; everything else stays in uart_rx_param.

Verification
REQ-035 DATA_W=8, even, baud_div=3, send 0xA5 with parity 0 -> rx_data=0xA5, rx_valid=1, perror=0, ferror=0.
REQ-036 Odd mode, send 0x3C with parity 0 -> rx_data=0x3C, rx_perror=1; the next clean frame 0x01 is received normally.
REQ-037 rxd low for 3 ticks then high -> no rx_valid, FSM back in IDLE, no flags.
REQ-038 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, rx_overrun=1; raising rx_ready clears all flags.
REQ-039 stop2=1 with second stop bit low -> rx_ferror=1; reset pulsed mid-frame -> all outputs 0, next frame clean.
REQ-040 With the macro, hold rxd low for 12 bit times -> exactly one rx_break pulse, no rx_valid.
